fir_stimulus_gen: RTL

Programmable test-sample source that drives the 16-bit signed sample input of the team's FIR/moving-average filters. It produces impulse, step, square, ramp and pseudo-noise sequences at a programmable sample rate. Each burst ends with a zero-valued flush so the filter delay line drains before done is signalled. Used in on-chip self-test and in filter benches as the writer side of the sample stream.

---
 rtl/fir_stimulus_gen_if.sv | 27 ++
 rtl/fir_stimulus_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fir_stimulus_gen_if.sv
// rtl/fir_stimulus_gen_if.sv - control and sample-stream bundle for fir_stimulus_gen
interface fir_stimulus_gen_if #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 8
);
    logic                     start;
    logic                     stop;
    logic [2:0]               mode;
    logic signed [DATA_W-1:0] amplitude;
    logic [15:0]              period;
    logic [15:0]              length;
    logic [DIV_W-1:0]         rate_div;
    logic signed [DATA_W-1:0] out;
    logic                     out_valid;
    logic                     busy;
    logic                     done;

    modport master (
        output start, stop, mode, amplitude, period, length, rate_div,
        input  out, out_valid, busy, done
    );

    modport slave (
        input  start, stop, mode, amplitude, period, length, rate_div,
        output out, out_valid, busy, done
    );
endinterface

// File: rtl/fir_stimulus_gen.sv
// rtl/fir_stimulus_gen.sv - programmable impulse/step/square/ramp/noise sample source with zero flush
module fir_stimulus_gen #(
    parameter int          DATA_W    = 16,
    parameter int          DIV_W     = 8,
    parameter int          FLUSH_LEN = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_stimulus_gen_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    state_t                   state;
    logic [DIV_W-1:0]         div;
    logic [15:0]              n;
    logic [15:0]              fcnt;
    logic [15:0]              lfsr;
    logic signed [DATA_W-1:0] acc;
    logic [15:0]              sq_cnt;
    logic                     sq_neg;

    logic [2:0]               mode_q;
    logic signed [DATA_W-1:0] amp_q;
    logic [15:0]              period_q;
    logic [15:0]              length_q;
    logic [DIV_W-1:0]         rate_q;

    logic                     start_go, stop_go;
    logic [2:0]               c_mode;
    logic signed [DATA_W-1:0] c_amp;
    logic [15:0]              c_period;
    logic [DIV_W-1:0]         c_rate;
    logic [DIV_W-1:0]         p_div;
    logic                     strobe;
    logic [15:0]              s_n, s_sq_cnt, s_lfsr, period_eff;
    logic signed [DATA_W-1:0] s_acc;
    logic                     s_sq_neg, sq_last;
    logic [15:0]              lfsr_nxt;
    logic signed [DATA_W-1:0] neg_amp, wave;
    logic                     sample_fire, flush_fire;

    assign start_go = (state == IDLE) && bus.start;
    assign stop_go  = (state == RUN) && bus.stop;

    // On the accepting cycle the config inputs and fresh burst state are used directly,
    // so a rate_div of 0 can emit sample 0 on the same edge that accepts start.
    always_comb begin
        c_mode   = start_go ? bus.mode      : mode_q;
        c_amp    = start_go ? bus.amplitude : amp_q;
        c_period = start_go ? bus.period    : period_q;
        c_rate   = start_go ? bus.rate_div  : rate_q;
        s_n      = start_go ? 16'd0         : n;
        s_acc    = start_go ? '0            : acc;
        s_sq_cnt = start_go ? 16'd0         : sq_cnt;
        s_sq_neg = start_go ? 1'b0          : sq_neg;
        s_lfsr   = start_go ? LFSR_SEED     : lfsr;
        // start and stop both restart the rate phase at zero
        p_div    = (start_go || stop_go) ? '0 : div;
        strobe   = (p_div == c_rate);
    end

    always_comb begin
        period_eff = (c_period == 16'd0) ? 16'd1 : c_period;
        sq_last    = (s_sq_cnt == period_eff - 16'd1);
        lfsr_nxt   = {s_lfsr[0] ^ s_lfsr[2] ^ s_lfsr[3] ^ s_lfsr[5], s_lfsr[15:1]};
        neg_amp    = (c_amp == S_MIN) ? S_MAX : -c_amp;
        wave       = '0;
        unique case (c_mode)
            3'd0:    wave = (s_n == 16'd0) ? c_amp : '0;
            3'd1:    wave = c_amp;
            3'd2:    wave = s_sq_neg ? neg_amp : c_amp;
            3'd3:    wave = s_acc;
            3'd4:    wave = DATA_W'(lfsr_nxt);
            default: wave = '0;
        endcase
    end

    always_comb begin
        sample_fire = strobe &&
                      ((start_go && bus.length != 16'd0) ||
                       (state == RUN && !stop_go && n != length_q));
        flush_fire  = strobe &&
                      ((start_go && bus.length == 16'd0) ||
                       stop_go ||
                       (state == RUN && n == length_q) ||
                       (state == FLUSH && fcnt != 16'(FLUSH_LEN)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus.out   <= '0;
            bus.out_valid <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            div       <= '0;
            n         <= 16'd0;
            fcnt      <= 16'd0;
            lfsr      <= LFSR_SEED;
            acc       <= '0;
            sq_cnt    <= 16'd0;
            sq_neg    <= 1'b0;
            mode_q    <= 3'd0;
            amp_q     <= '0;
            period_q  <= 16'd0;
            length_q  <= 16'd0;
            rate_q    <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    div <= '0;
                    if (bus.start) begin
                        mode_q   <= bus.mode;
                        amp_q    <= bus.amplitude;
                        period_q <= bus.period;
                        length_q <= bus.length;
                        rate_q   <= bus.rate_div;
                        bus.busy <= 1'b1;
                        n        <= 16'd0;
                        acc      <= '0;
                        sq_cnt   <= 16'd0;
                        sq_neg   <= 1'b0;
                        lfsr     <= LFSR_SEED;
                        div      <= strobe ? '0 : p_div + 1'b1;
                        state    <= (bus.length == 16'd0) ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    div <= strobe ? '0 : p_div + 1'b1;
                    if (stop_go || (strobe && n == length_q))
                        state <= FLUSH;
                end
                FLUSH: begin
                    if (fcnt == 16'(FLUSH_LEN)) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.out  <= '0;
                        div      <= '0;
                        fcnt     <= 16'd0;
                    end else begin
                        div <= strobe ? '0 : p_div + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (sample_fire) begin
                bus.out       <= wave;
                bus.out_valid <= 1'b1;
                n             <= s_n + 16'd1;
                acc           <= s_acc + c_amp;
                sq_cnt        <= sq_last ? 16'd0 : s_sq_cnt + 16'd1;
                sq_neg        <= s_sq_neg ^ sq_last;
                lfsr          <= lfsr_nxt;
            end
            if (flush_fire) begin
                bus.out       <= '0;
                bus.out_valid <= 1'b1;
                fcnt          <= fcnt + 16'd1;
            end
        end
    end
endmodule
